dma_mc: RTL

Multi-channel, parametrised DMA engine. It moves words between per-channel devices and system memory over the shared memory bus. Each channel is programmed by the CPU through a register window and can run device-to-memory (wr) or memory-to-device (rd). Active channels are served round-robin, one word per bus grant. The block sits between the CPU register bus, the memory-bus arbiter (grant/ready) and up to NCH peripheral devices.

---
 rtl/dma_mc.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/dma_mc.sv
// Multi-channel DMA engine: round-robin service of CPU-programmed channels, one word per grant.
// Define DMA_IRQ_EN to enable the per-channel ie bit and the registered done interrupt.
module dma_mc #(
    parameter int unsigned NCH = 2,
    parameter int unsigned DW  = 32,
    parameter int unsigned AW  = 32,
    parameter int unsigned CW  = 16,
    parameter int unsigned SW  = $clog2(NCH) + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              status_wr,
    input  logic              status_rd,
    input  logic [SW-1:0]     select_reg,
    input  logic [DW-1:0]     cpu_wdata,
    output logic [DW-1:0]     cpu_rdata,
    output logic              read_mem,
    output logic              write_mem,
    output logic [AW-1:0]     adbus,
    output logic [DW-1:0]     bus_wdata,
    output logic              bus_drive,
    input  logic [DW-1:0]     bus_rdata,
    input  logic              grant,
    input  logic              ready,
    input  logic [NCH-1:0]    dev_rdy,
    input  logic [NCH*DW-1:0] dev_data,
    output logic [NCH-1:0]    dev_rcv,
    input  logic [2*NCH-1:0]  dev_err,
    output logic [DW-1:0]     dev_out_data,
    output logic [NCH-1:0]    dev_out_vld,
    input  logic [NCH-1:0]    dev_out_ack,
    output logic              irq
);
`ifdef DMA_IRQ_EN
    localparam bit IrqEn = 1'b1;
`else
    localparam bit IrqEn = 1'b0;
`endif
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {
        StIdle, StArb, StDevWait, StBusReq, StBusXfer, StDevPush, StUpdate
    } state_e;

    state_e                  state;
    logic [NCH-1:0]          go, rd_mode, wr_mode, ie, err1, err2, done;
    logic [NCH-1:0][AW-1:0]  addr;
    logic [NCH-1:0][CW-1:0]  count;
    logic [CHW-1:0]          cur, rr_ptr, pend_ch;
    logic                    cur_wr, pend_vld, pend_go;
    logic [DW-1:0]           data_buf;
    logic [1:0]              err_buf;

    logic [NCH-1:0]          eligible, degenerate, busy;
    logic                    pick_vld, sel_ok, upd_hit;
    logic [CHW-1:0]          pick, scan, sel_ch;
    logic [1:0]              sel_idx;

    assign sel_idx = select_reg[1:0];
    assign sel_ch  = CHW'(select_reg >> 2);
    assign sel_ok  = (32'(select_reg) >> 2) < NCH;
    assign upd_hit = (state == StUpdate) && (sel_ch == cur);

    always_comb begin
        pick_vld = 1'b0;
        pick     = rr_ptr;
        scan     = '0;
        for (int c = 0; c < NCH; c++) begin
            degenerate[c] = go[c] && !done[c] && ((rd_mode[c] == wr_mode[c]) || (count[c] == '0));
            eligible[c]   = go[c] && !done[c] && !degenerate[c];
            busy[c]       = (state != StIdle) && (state != StArb) && (cur == CHW'(c));
        end
        // First eligible channel at or after the pointer wins.
        for (int unsigned i = 0; i < NCH; i++) begin
            scan = CHW'((32'(rr_ptr) + i) % NCH);
            if (eligible[scan] && !pick_vld) begin
                pick_vld = 1'b1;
                pick     = scan;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
            {go, rd_mode, wr_mode, ie, err1, err2, done} <= '0;
            addr <= '0;
            count <= '0;
            {cur, rr_ptr, pend_ch, cur_wr, pend_vld, pend_go} <= '0;
            data_buf <= '0;
            err_buf <= '0;
            {cpu_rdata, read_mem, write_mem, adbus, bus_wdata, bus_drive} <= '0;
            {dev_rcv, dev_out_data, dev_out_vld, irq} <= '0;
        end else begin
            dev_rcv <= '0;
            irq <= IrqEn & |(done & ie);

            // A CTRL go that collided with UPDATE lands one cycle later.
            pend_vld <= 1'b0;
            if (pend_vld) begin
                go[pend_ch] <= pend_go;
                if (pend_go) {done[pend_ch], err1[pend_ch], err2[pend_ch]} <= 3'b000;
            end

            for (int c = 0; c < NCH; c++) begin
                if (degenerate[c] && !busy[c]) begin
                    done[c] <= 1'b1;
                    go[c]   <= 1'b0;
                end
            end

            if (status_wr && sel_ok) begin
                case (sel_idx)
                    2'd0: begin
                        rd_mode[sel_ch] <= cpu_wdata[1];
                        wr_mode[sel_ch] <= cpu_wdata[2];
                        ie[sel_ch]      <= cpu_wdata[3] & IrqEn;
                        if (upd_hit) begin
                            pend_vld <= 1'b1;
                            pend_ch  <= sel_ch;
                            pend_go  <= cpu_wdata[0];
                        end else begin
                            go[sel_ch] <= cpu_wdata[0];
                            if (cpu_wdata[0]) {err1[sel_ch], err2[sel_ch]} <= 2'b00;
                            if (cpu_wdata[0] || cpu_wdata[6]) done[sel_ch] <= 1'b0;
                        end
                    end
                    2'd1: if (!busy[sel_ch]) addr[sel_ch] <= AW'(cpu_wdata);
                    2'd2: if (!busy[sel_ch]) count[sel_ch] <= CW'(cpu_wdata);
                    default: ;
                endcase
            end

            if (status_rd) begin
                cpu_rdata <= '0;
                if (sel_ok) begin
                    case (sel_idx)
                        2'd0: cpu_rdata <= DW'({busy[sel_ch], done[sel_ch], err2[sel_ch],
                                                err1[sel_ch], ie[sel_ch], wr_mode[sel_ch],
                                                rd_mode[sel_ch], go[sel_ch]});
                        2'd1: cpu_rdata <= DW'(addr[sel_ch]);
                        2'd2: cpu_rdata <= DW'(count[sel_ch]);
                        default: ;
                    endcase
                end
            end

            case (state)
                StIdle: if (|eligible) state <= StArb;
                StArb: begin
                    err_buf <= 2'b00;
                    if (pick_vld) begin
                        cur    <= pick;
                        rr_ptr <= (32'(pick) == NCH - 1) ? '0 : pick + 1'b1;
                        cur_wr <= wr_mode[pick];
                        if (wr_mode[pick]) begin
                            state <= StDevWait;
                        end else begin
                            state    <= StBusReq;
                            read_mem <= 1'b1;
                            adbus    <= addr[pick];
                        end
                    end else begin
                        state <= StIdle;
                    end
                end
                StDevWait: begin
                    if (dev_rdy[cur]) begin
                        data_buf     <= dev_data[cur*DW +: DW];
                        err_buf      <= dev_err[cur*2 +: 2];
                        dev_rcv[cur] <= 1'b1;
                        if (|dev_err[cur*2 +: 2]) begin
                            state <= StUpdate;
                        end else begin
                            state     <= StBusReq;
                            write_mem <= 1'b1;
                            adbus     <= addr[cur];
                        end
                    end else if (!go[cur]) begin
                        // Abort while the device is idle: nothing moved, count untouched.
                        done[cur] <= 1'b1;
                        state     <= StIdle;
                    end
                end
                StBusReq: begin
                    if (grant) begin
                        state <= StBusXfer;
                        if (cur_wr) begin
                            bus_wdata <= data_buf;
                            bus_drive <= 1'b1;
                        end
                    end
                end
                StBusXfer: begin
                    if (ready) begin
                        read_mem  <= 1'b0;
                        write_mem <= 1'b0;
                        bus_drive <= 1'b0;
                        if (cur_wr) begin
                            state <= StUpdate;
                        end else begin
                            dev_out_data     <= bus_rdata;
                            dev_out_vld[cur] <= 1'b1;
                            state            <= StDevPush;
                        end
                    end
                end
                StDevPush: begin
                    if (dev_out_ack[cur]) begin
                        dev_out_vld[cur] <= 1'b0;
                        state            <= StUpdate;
                    end
                end
                StUpdate: begin
                    addr[cur]  <= addr[cur] + AW'(4);
                    count[cur] <= count[cur] - 1'b1;
                    if ((count[cur] == CW'(1)) || (err_buf != 2'b00) || !go[cur]) begin
                        done[cur] <= 1'b1;
                        go[cur]   <= 1'b0;
                        err1[cur] <= err1[cur] | err_buf[0];
                        err2[cur] <= err2[cur] | err_buf[1];
                    end
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
